wb_scoreboard: RTL and testbench

// - Write-side master of the register file.
// - Tracks destination registers still owed by long-latency units (load/mul/div) and holds off issue on RAW/WAW hazards.
// - Merges the single-cycle ALU result stream and the long-latency result stream onto the register file's single write port.
// - Sits between decode/issue and the register file; drives its reg_wr_en/rd_addr/w_data inputs.

---
 rtl/rv_regs_pkg.sv | 14 +
 rtl/wb_scoreboard_if.sv | 45 ++++
 rtl/wb_fifo.sv | 57 +++++
 rtl/wb_scoreboard.sv | 150 +++++++++++++++
 tb/tb_wb_scoreboard.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_regs_pkg.sv
// Shared register-file constants and the write-back entry type.
// Used by the scoreboard, its skid FIFO and the bus interface.
package rv_regs_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREG   = 32;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_scoreboard_if.sv
// Issue, write-back and register-file write bundle of the scoreboard.
// master = decode/exec side driving it, slave = the scoreboard.
interface wb_scoreboard_if;
    import rv_regs_pkg::*;

    logic              issue_valid;
    logic              issue_ready;
    logic [REG_AW-1:0] issue_rs1;
    logic [REG_AW-1:0] issue_rs2;
    logic [REG_AW-1:0] issue_rd;
    logic              issue_rd_we;
    logic              issue_long;

    logic              alu_wb_valid;
    logic [REG_AW-1:0] alu_wb_rd;
    logic [XLEN-1:0]   alu_wb_data;

    logic              long_wb_valid;
    logic              long_wb_ready;
    logic [REG_AW-1:0] long_wb_rd;
    logic [XLEN-1:0]   long_wb_data;

    logic              reg_wr_en;
    logic [REG_AW-1:0] rd_addr;
    logic [XLEN-1:0]   w_data;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rd,
        output issue_rd_we, issue_long,
        output alu_wb_valid, alu_wb_rd, alu_wb_data,
        output long_wb_valid, long_wb_rd, long_wb_data,
        input  issue_ready, long_wb_ready,
        input  reg_wr_en, rd_addr, w_data
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rd,
        input  issue_rd_we, issue_long,
        input  alu_wb_valid, alu_wb_rd, alu_wb_data,
        input  long_wb_valid, long_wb_rd, long_wb_data,
        output issue_ready, long_wb_ready,
        output reg_wr_en, rd_addr, w_data
    );

endinterface

// File: rtl/wb_fifo.sv
// Skid FIFO for long-latency write-back entries.
// Pointers carry a phase bit to tell full from empty.
module wb_fifo
    import rv_regs_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  wb_entry_t din_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    wb_entry_t   mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Advance pointers on accepted push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    // Pointer state
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/wb_scoreboard.sv
// Register-file write-side master: pending-register scoreboard,
// issue hazard check and ALU/long-result write-port merge.
module wb_scoreboard
    import rv_regs_pkg::*;
#(
    parameter int LQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    wb_scoreboard_if.slave  bus,
    output logic [NREG-1:0] pending,
    output logic            proto_err
);

    logic [NREG-1:0]   pending_q, pending_d;
    logic              proto_q, proto_d;
    logic              wr_en_q, wr_en_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   data_q, data_d;

    logic              issue_fire;
    logic              long_fire;
    logic              long_keep;
    logic              alu_fire;
    logic              use_fifo;
    logic              use_bypass;
    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic              clr_en;
    logic [REG_AW-1:0] clr_rd;
    wb_entry_t         long_ent;
    wb_entry_t         fifo_head;

    assign bus.issue_ready = !pending_q[bus.issue_rs1] &&
                             !pending_q[bus.issue_rs2] &&
                             !(bus.issue_rd_we &&
                               pending_q[bus.issue_rd]);

    assign issue_fire = bus.issue_valid && bus.issue_ready &&
                        bus.issue_rd_we && bus.issue_long &&
                        (bus.issue_rd != '0);

    assign bus.long_wb_ready = !fifo_full;

    assign long_fire = bus.long_wb_valid && !fifo_full;
    assign long_keep = long_fire && (bus.long_wb_rd != '0);
    assign alu_fire  = bus.alu_wb_valid && (bus.alu_wb_rd != '0);

    // Any ALU beat owns the port; an empty FIFO lets a
    // fresh long result go straight to the output register.
    assign use_fifo   = !bus.alu_wb_valid && !fifo_empty;
    assign use_bypass = !bus.alu_wb_valid && fifo_empty && long_keep;
    assign fifo_push  = long_keep && !use_bypass;

    assign long_ent = '{rd: bus.long_wb_rd, data: bus.long_wb_data};

    wb_fifo #(
        .DEPTH (LQ_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .din_i   (long_ent),
        .pop_i   (use_fifo),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Select the source loaded into the write-port register
    always_comb begin
        wr_en_d = 1'b0;
        rd_d    = rd_q;
        data_d  = data_q;
        clr_en  = 1'b0;
        clr_rd  = '0;
        unique case (1'b1)
            alu_fire: begin
                wr_en_d = 1'b1;
                rd_d    = bus.alu_wb_rd;
                data_d  = bus.alu_wb_data;
            end
            use_fifo: begin
                wr_en_d = 1'b1;
                rd_d    = fifo_head.rd;
                data_d  = fifo_head.data;
                clr_en  = 1'b1;
                clr_rd  = fifo_head.rd;
            end
            use_bypass: begin
                wr_en_d = 1'b1;
                rd_d    = bus.long_wb_rd;
                data_d  = bus.long_wb_data;
                clr_en  = 1'b1;
                clr_rd  = bus.long_wb_rd;
            end
            default: begin
                wr_en_d = 1'b0;
            end
        endcase
    end

    // Pending update: set after clear so a forced collision sets
    always_comb begin
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[clr_rd] = 1'b0;
        end
        if (issue_fire) begin
            pending_d[bus.issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Sticky protocol checks against the current scoreboard
    always_comb begin
        proto_d = proto_q;
        if (bus.alu_wb_valid && pending_q[bus.alu_wb_rd]) begin
            proto_d = 1'b1;
        end
        if (long_keep && !pending_q[bus.long_wb_rd]) begin
            proto_d = 1'b1;
        end
    end

    // Scoreboard, error flag and write-port registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            proto_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
        end else begin
            pending_q <= pending_d;
            proto_q   <= proto_d;
            wr_en_q   <= wr_en_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
        end
    end

    assign bus.reg_wr_en = wr_en_q;
    assign bus.rd_addr   = rd_q;
    assign bus.w_data    = data_q;
    assign pending       = pending_q;
    assign proto_err     = proto_q;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed self-checking bench for wb_scoreboard.
// Inputs change 1ns after posedge; outputs are checked there too.
module tb_wb_scoreboard;
    import rv_regs_pkg::*;

    logic            clk;
    logic            rst;
    logic [NREG-1:0] pending;
    logic            proto_err;
    int              checks;
    int              errors;

    wb_scoreboard_if bus();

    wb_scoreboard #(
        .LQ_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .pending   (pending),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid   = 1'b0;
        bus.issue_rs1     = '0;
        bus.issue_rs2     = '0;
        bus.issue_rd      = '0;
        bus.issue_rd_we   = 1'b0;
        bus.issue_long    = 1'b0;
        bus.alu_wb_valid  = 1'b0;
        bus.alu_wb_rd     = '0;
        bus.alu_wb_data   = '0;
        bus.long_wb_valid = 1'b0;
        bus.long_wb_rd    = '0;
        bus.long_wb_data  = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic issue_long(input logic [REG_AW-1:0] rd);
        bus.issue_valid = 1'b1;
        bus.issue_rs1   = '0;
        bus.issue_rs2   = '0;
        bus.issue_rd    = rd;
        bus.issue_rd_we = 1'b1;
        bus.issue_long  = 1'b1;
        step();
        bus.issue_valid = 1'b0;
        bus.issue_rd_we = 1'b0;
        bus.issue_long  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bus.reg_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %0b want 0", bus.reg_wr_en); end
        checks++; if (bus.rd_addr !== 5'd0) begin errors++; $display("FAIL rst_rd_addr: got %0d want 0", bus.rd_addr); end
        checks++; if (bus.w_data !== 32'd0) begin errors++; $display("FAIL rst_w_data: got %h want 0", bus.w_data); end
        checks++; if (pending !== 32'd0) begin errors++; $display("FAIL rst_pending: got %h want 0", pending); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto: got %0b want 0", proto_err); end
        checks++; if (bus.long_wb_ready !== 1'b1) begin errors++; $display("FAIL rst_long_ready: got %0b want 1", bus.long_wb_ready); end
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL rst_issue_ready: got %0b want 1", bus.issue_ready); end
    endtask

    task automatic test_alu_write();
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_rd    = 5'd5;
        bus.alu_wb_data  = 32'hDEADBEEF;
        step();
        idle();
        checks++; if (bus.reg_wr_en !== 1'b1) begin errors++; $display("FAIL alu_wr_en: got %0b want 1", bus.reg_wr_en); end
        checks++; if (bus.rd_addr !== 5'd5) begin errors++; $display("FAIL alu_rd_addr: got %0d want 5", bus.rd_addr); end
        checks++; if (bus.w_data !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_w_data: got %h want deadbeef", bus.w_data); end
        checks++; if (pending !== 32'd0) begin errors++; $display("FAIL alu_pending: got %h want 0", pending); end
        step();
        checks++; if (bus.reg_wr_en !== 1'b0) begin errors++; $display("FAIL alu_idle_wr_en: got %0b want 0", bus.reg_wr_en); end
    endtask

    task automatic test_long_hazard();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        bus.issue_rd_we = 1'b1;
        bus.issue_long  = 1'b1;
        #1;
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL haz_first_ready: got %0b want 1", bus.issue_ready); end
        step();
        bus.issue_rd_we = 1'b0;
        bus.issue_long  = 1'b0;
        bus.issue_rd    = 5'd0;
        bus.issue_rs1   = 5'd7;
        #1;
        checks++; if (pending !== 32'h0000_0080) begin errors++; $display("FAIL haz_pending_set: got %h want 00000080", pending); end
        checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("FAIL haz_blocked: got %0b want 0", bus.issue_ready); end
        bus.issue_valid   = 1'b0;
        bus.long_wb_valid = 1'b1;
        bus.long_wb_rd    = 5'd7;
        bus.long_wb_data  = 32'h0000_1234;
        #1;
        checks++; if (bus.long_wb_ready !== 1'b1) begin errors++; $display("FAIL haz_long_ready: got %0b want 1", bus.long_wb_ready); end
        step();
        bus.long_wb_valid = 1'b0;
        bus.issue_valid   = 1'b1;
        #1;
        checks++; if (bus.reg_wr_en !== 1'b1) begin errors++; $display("FAIL haz_wr_en: got %0b want 1", bus.reg_wr_en); end
        checks++; if (bus.rd_addr !== 5'd7) begin errors++; $display("FAIL haz_rd_addr: got %0d want 7", bus.rd_addr); end
        checks++; if (bus.w_data !== 32'h0000_1234) begin errors++; $display("FAIL haz_w_data: got %h want 00001234", bus.w_data); end
        checks++; if (pending !== 32'd0) begin errors++; $display("FAIL haz_pending_clr: got %h want 0", pending); end
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL haz_released: got %0b want 1", bus.issue_ready); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL haz_proto: got %0b want 0", proto_err); end
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        logic [REG_AW-1:0] exp_rd [4];
        logic [XLEN-1:0]   exp_dat [4];
        exp_rd[0] = 5'd10; exp_dat[0] = 32'hA000_0000;
        exp_rd[1] = 5'd11; exp_dat[1] = 32'hA000_0001;
        exp_rd[2] = 5'd12; exp_dat[2] = 32'hA000_0002;
        exp_rd[3] = 5'd13; exp_dat[3] = 32'hA000_0003;
        issue_long(5'd3);
        issue_long(5'd4);
        checks++; if (pending !== 32'h0000_0018) begin errors++; $display("FAIL b2b_pending: got %h want 00000018", pending); end
        for (int i = 0; i < 4; i++) begin
            bus.alu_wb_valid  = 1'b1;
            bus.alu_wb_rd     = exp_rd[i];
            bus.alu_wb_data   = exp_dat[i];
            bus.long_wb_valid = 1'b1;
            bus.long_wb_rd    = (i == 0) ? 5'd3 : (i == 1) ? 5'd4 : 5'd5;
            bus.long_wb_data  = (i == 0) ? 32'h33 : (i == 1) ? 32'h44 : 32'h55;
            #1;
            checks++; if (bus.long_wb_ready !== (i < 2)) begin errors++; $display("FAIL b2b_long_ready%0d: got %0b want %0b", i, bus.long_wb_ready, (i < 2)); end
            step();
            checks++; if (bus.reg_wr_en !== 1'b1 || bus.rd_addr !== exp_rd[i] || bus.w_data !== exp_dat[i]) begin
                errors++;
                $display("FAIL b2b_alu%0d: got en=%0b rd=%0d d=%h want en=1 rd=%0d d=%h", i, bus.reg_wr_en, bus.rd_addr, bus.w_data, exp_rd[i], exp_dat[i]);
            end
        end
        idle();
        checks++; if (pending !== 32'h0000_0018) begin errors++; $display("FAIL b2b_pending_held: got %h want 00000018", pending); end
        step();
        checks++; if (bus.reg_wr_en !== 1'b1 || bus.rd_addr !== 5'd3 || bus.w_data !== 32'h33) begin errors++; $display("FAIL b2b_pop3: got en=%0b rd=%0d d=%h want en=1 rd=3 d=33", bus.reg_wr_en, bus.rd_addr, bus.w_data); end
        checks++; if (pending !== 32'h0000_0010) begin errors++; $display("FAIL b2b_pending3: got %h want 00000010", pending); end
        checks++; if (bus.long_wb_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_back: got %0b want 1", bus.long_wb_ready); end
        step();
        checks++; if (bus.reg_wr_en !== 1'b1 || bus.rd_addr !== 5'd4 || bus.w_data !== 32'h44) begin errors++; $display("FAIL b2b_pop4: got en=%0b rd=%0d d=%h want en=1 rd=4 d=44", bus.reg_wr_en, bus.rd_addr, bus.w_data); end
        checks++; if (pending !== 32'd0) begin errors++; $display("FAIL b2b_pending4: got %h want 0", pending); end
        step();
        checks++; if (bus.reg_wr_en !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %0b want 0", bus.reg_wr_en); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL b2b_proto: got %0b want 0", proto_err); end
    endtask

    task automatic test_zero_reg();
        bus.alu_wb_valid  = 1'b1;
        bus.alu_wb_rd     = 5'd0;
        bus.alu_wb_data   = 32'hFF;
        bus.long_wb_valid = 1'b1;
        bus.long_wb_rd    = 5'd0;
        bus.long_wb_data  = 32'hEE;
        step();
        idle();
        checks++; if (bus.reg_wr_en !== 1'b0) begin errors++; $display("FAIL zero_wr_en: got %0b want 0", bus.reg_wr_en); end
        checks++; if (pending !== 32'd0) begin errors++; $display("FAIL zero_pending: got %h want 0", pending); end
        step();
        checks++; if (bus.reg_wr_en !== 1'b0) begin errors++; $display("FAIL zero_no_late: got %0b want 0", bus.reg_wr_en); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL zero_proto: got %0b want 0", proto_err); end
    endtask

    task automatic test_reset_mid_flight();
        issue_long(5'd9);
        bus.alu_wb_valid  = 1'b1;
        bus.alu_wb_rd     = 5'd1;
        bus.alu_wb_data   = 32'h1;
        bus.long_wb_valid = 1'b1;
        bus.long_wb_rd    = 5'd9;
        bus.long_wb_data  = 32'h99;
        step();
        idle();
        checks++; if (pending !== 32'h0000_0200) begin errors++; $display("FAIL rmf_pending_pre: got %h want 00000200", pending); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (pending !== 32'd0) begin errors++; $display("FAIL rmf_pending: got %h want 0", pending); end
        checks++; if (bus.reg_wr_en !== 1'b0) begin errors++; $display("FAIL rmf_wr_en: got %0b want 0", bus.reg_wr_en); end
        checks++; if (bus.long_wb_ready !== 1'b1) begin errors++; $display("FAIL rmf_long_ready: got %0b want 1", bus.long_wb_ready); end
        step();
        checks++; if (bus.reg_wr_en !== 1'b0) begin errors++; $display("FAIL rmf_fifo_empty: got %0b want 0", bus.reg_wr_en); end
        bus.issue_valid = 1'b1;
        bus.issue_rs1   = 5'd9;
        #1;
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL rmf_issue_ready: got %0b want 1", bus.issue_ready); end
        idle();
    endtask

    task automatic test_proto_err();
        issue_long(5'd9);
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_rd    = 5'd9;
        bus.alu_wb_data  = 32'h0909;
        step();
        idle();
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_alu: got %0b want 1", proto_err); end
        checks++; if (bus.reg_wr_en !== 1'b1 || bus.rd_addr !== 5'd9 || bus.w_data !== 32'h0909) begin errors++; $display("FAIL perr_alu_write: got en=%0b rd=%0d d=%h want en=1 rd=9 d=909", bus.reg_wr_en, bus.rd_addr, bus.w_data); end
        checks++; if (pending !== 32'h0000_0200) begin errors++; $display("FAIL perr_pending: got %h want 00000200", pending); end
        step();
        step();
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %0b want 1", proto_err); end
        do_reset();
        bus.long_wb_valid = 1'b1;
        bus.long_wb_rd    = 5'd20;
        bus.long_wb_data  = 32'h2020;
        step();
        idle();
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_long: got %0b want 1", proto_err); end
        checks++; if (bus.reg_wr_en !== 1'b1 || bus.rd_addr !== 5'd20 || bus.w_data !== 32'h2020) begin errors++; $display("FAIL perr_long_write: got en=%0b rd=%0d d=%h want en=1 rd=20 d=2020", bus.reg_wr_en, bus.rd_addr, bus.w_data); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle();
        test_reset();
        test_alu_write();
        test_long_hazard();
        test_back_to_back();
        test_zero_reg();
        test_reset_mid_flight();
        test_proto_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
